plot_sink_fb_writer: RTL
========================

// Module: plot_sink_fb_writer
// PURPOSE
//  Receiving end of the pixel-plot stream (x, y, colour, plot) driven by cube_drawer.
//  Buffers plot requests and serialises them into framebuffer RAM writes.
//  Also runs a full-screen clear sweep on request.
//  Adds `ready` back-pressure so the drawer can stall instead of losing pixels.
// PARAMETERS
//  SCREEN_W    160  visible width in pixels; x range 0..SCREEN_W-1
//  SCREEN_H    120  visible height in pixels; y range 0..SCREEN_H-1
//  FIFO_DEPTH  8    plot buffer entries; must be a power of 2 and >= 2
// PORTS
//  clk           in   1   system clock (CLOCK_50 at top)
//  resetn        in   1   asynchronous active-low reset
//  x             in   8   plot x coordinate
//  y             in   7   plot y coordinate
//  colour        in   3   plot colour (RGB, 1 bit each)
//  plot          in   1   plot request valid
//  ready         out  1   sink can accept a plot this cycle
//  clear_req     in   1   one-cycle pulse: clear whole screen
//  clear_colour  in   3   fill colour, sampled on the accepted clear_req
//  busy          out  1   FSM not IDLE, or FIFO not empty
//  fb_addr       out  15  framebuffer write address, = y*SCREEN_W + x
//  fb_data       out  3   framebuffer write data
//  fb_we         out  1   framebuffer write enable, one write per cycle
//  drop_count    out  8   saturating count of plots seen while ready=0
// BEHAVIOUR
//  - Reset values: ready=0 on the reset cycle, then 1 on the first clk edge with resetn=1.
//    fb_we=0, fb_addr=0, fb_data=0, busy=0, drop_count=0, FIFO empty, FSM=IDLE.
//  - Handshake: a plot is accepted on a rising edge where plot && ready.
//    plot && !ready: the pixel is dropped and drop_count increments (saturates at 255).
//  - ready = FIFO not full && FSM==IDLE. It is registered, based on the post-edge state.
//  - Write path: FIFO pop -> registered address multiply-add -> fb_we.
//    A plot accepted at edge N into an empty FIFO gives fb_we=1 after edge N+2.
//    Sustained throughput is 1 write per cycle.
//  - FIFO full with a simultaneous push and pop: ready stays 0 that cycle.
//    Push and pop in the same cycle on a non-full FIFO: occupancy is unchanged.
//  - FSM states:
//    IDLE  -> DRAIN  on clear_req; clear_colour latched; ready drops next cycle.
//    DRAIN -> CLEAR  once the FIFO is empty and the write pipeline is idle.
//    CLEAR: fb_addr sweeps 0..SCREEN_W*SCREEN_H-1, 1 per cycle, fb_we=1, fb_data=latched colour.
//    CLEAR -> IDLE   after address SCREEN_W*SCREEN_H-1 is written.
//  - clear_req is ignored outside IDLE.
//  - clear_req and an accepted plot in the same cycle: the plot is enqueued first,
//    then written during DRAIN, before the sweep.
//  - Arithmetic: the address is computed at 15 bits, unsigned; 159 + 119*160 = 19199 fits.
//  - resetn low mid-sweep or mid-drain: everything aborts immediately.
//    fb_we=0 asynchronously and the FIFO contents are discarded.
// CONFIGURATION
//  - PLOT_SINK_BOUNDS_CHECK_EN defined:
//    x>=SCREEN_W or y>=SCREEN_H is accepted (ready honoured) but discarded at the FIFO input.
//    No fb write results. Extra output oob_count[7:0] (saturating) counts these plots.
//  - Macro undefined:
//    No check; the address is the truncated 15-bit y*SCREEN_W+x and is written as-is.
//    There is no oob_count port.
// STRUCTURE
//  - cube_pkg holds:
//    SCREEN_W/SCREEN_H defaults, FB_AW=15, FB_WORDS=19200.
//    colour_t (3-bit) and plot_t struct {x, y, colour}.
//    FSM enum sink_state_t {IDLE, DRAIN, CLEAR}.
//  - Sub-module plot_fifo: synchronous FIFO of plot_t, parameter DEPTH.
//    Ports push/pop/full/empty/din/dout.
//  - Top-level integration places plot_sink_fb_writer between cube_drawer and the framebuffer RAM.
// TESTING
//  - Reset -> all outputs at reset values; ready=1 one cycle after resetn rises.
//  - Single plot x=5,y=2,colour=3'b101 -> fb_we pulse 2 cycles later, fb_addr=325, fb_data=5.
//  - Back-to-back stream of 20 plots with fb side free-running -> 20 consecutive writes.
//    Order preserved; ready never drops.
//  - clear_req with 3 plots queued, clear_colour=3'b010 ->
//    3 plot writes first, then 19200 writes addr 0..19199 data 2; ready=0 throughout; then IDLE.
//  - plot held high during CLEAR for 10 cycles -> drop_count=10; no extra fb writes.
//  - Macro defined: plot x=160,y=0 -> no fb_we, oob_count=1.
//    Macro undefined: fb_addr=160 written. resetn pulsed mid-sweep -> fb_we=0 at once, FSM=IDLE.

Source files
------------

// File: rtl/cube_pkg.sv
// Shared types and screen geometry for the plot sink and its framebuffer write path.
package cube_pkg;

  localparam int unsigned SCREEN_W_DEF = 160;
  localparam int unsigned SCREEN_H_DEF = 120;
  localparam int unsigned FB_AW        = 15;
  localparam int unsigned FB_WORDS     = 19200;

  typedef logic [2:0] colour_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    colour_t    colour;
  } plot_t;

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} sink_state_t;

  function automatic logic [FB_AW-1:0] fb_addr_of(input logic [7:0] x, input logic [6:0] y,
                                                  input int unsigned w);
    return FB_AW'(y) * FB_AW'(w) + FB_AW'(x);
  endfunction

endpackage

// File: rtl/plot_sink_fb_writer_if.sv
// Pixel-plot stream from cube_drawer to the sink, including the clear request.
interface plot_sink_fb_writer_if;
  import cube_pkg::*;

  logic [7:0] x;
  logic [6:0] y;
  colour_t    colour;
  logic       plot;
  logic       ready;
  logic       clear_req;
  colour_t    clear_colour;

  modport master (output x, y, colour, plot, clear_req, clear_colour, input ready);
  modport slave  (input x, y, colour, plot, clear_req, clear_colour, output ready);
endinterface

// File: rtl/plot_fifo.sv
// Synchronous FIFO of plot_t entries; DEPTH must be a power of 2 and >= 2.
module plot_fifo
  import cube_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  plot_t                  din,
  output plot_t                  dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  plot_t          mem [DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [AW:0]    cnt_q;
  logic           do_push, do_pop;

  assign full    = (cnt_q == FULL_LVL);
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end
endmodule

// File: rtl/plot_sink_fb_writer.sv
// Buffers plot requests into framebuffer writes and runs full-screen clear sweeps.
// Optional PLOT_SINK_BOUNDS_CHECK_EN drops off-screen plots and counts them on oob_count.
module plot_sink_fb_writer
  import cube_pkg::*;
#(
  parameter int unsigned SCREEN_W   = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H   = SCREEN_H_DEF,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  plot_sink_fb_writer_if.slave  ps,
  output logic                  busy,
  output logic [FB_AW-1:0]      fb_addr,
  output colour_t               fb_data,
  output logic                  fb_we,
  output logic [7:0]            drop_count
`ifdef PLOT_SINK_BOUNDS_CHECK_EN
  ,
  output logic [7:0]            oob_count
`endif
);
  localparam int unsigned      LW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0]    FULL_LVL  = FIFO_DEPTH[LW-1:0];
  localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(SCREEN_W * SCREEN_H - 1);

  sink_state_t      state_q, state_d;
  logic             ready_q, ready_d;
  colour_t          clr_colour_q, clr_colour_d;
  logic [FB_AW-1:0] clr_cnt_q, clr_cnt_d;
  plot_t            s1_q, s1_d;
  logic             s1_v_q, s1_v_d;
  logic [FB_AW-1:0] fb_addr_q, fb_addr_d;
  colour_t          fb_data_q, fb_data_d;
  logic             fb_we_q, fb_we_d;
  logic [7:0]       drop_q, drop_d;

  logic             accept, push, pop, full, empty;
  logic [LW-1:0]    level, level_next;
  plot_t            fifo_din, fifo_dout;

  assign accept   = ps.plot && ready_q;
  assign fifo_din = '{x: ps.x, y: ps.y, colour: ps.colour};
  assign pop      = !empty;

`ifdef PLOT_SINK_BOUNDS_CHECK_EN
  logic       in_bounds;
  logic [7:0] oob_q, oob_d;

  assign in_bounds = (32'(ps.x) < SCREEN_W) && (32'(ps.y) < SCREEN_H);
  assign push      = accept && in_bounds;
  assign oob_d     = (accept && !in_bounds && oob_q != 8'hFF) ? oob_q + 8'd1 : oob_q;
  assign oob_count = oob_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) oob_q <= '0;
    else         oob_q <= oob_d;
  end
`else
  assign push = accept;
`endif

  plot_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (resetn),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign level_next = level + LW'(push) - LW'(pop);

  always_comb begin
    state_d      = state_q;
    clr_colour_d = clr_colour_q;
    clr_cnt_d    = '0;
    s1_d         = fifo_dout;
    s1_v_d       = pop;
    fb_addr_d    = fb_addr_q;
    fb_data_d    = fb_data_q;
    fb_we_d      = 1'b0;
    drop_d       = (ps.plot && !ready_q && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

    unique case (state_q)
      IDLE: begin
        if (ps.clear_req) begin
          state_d      = DRAIN;
          clr_colour_d = ps.clear_colour;
        end
      end
      DRAIN: begin
        if (empty && !s1_v_q) state_d = CLEAR;
      end
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + FB_AW'(1);
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // The sweep owns the write port; the FIFO is guaranteed empty while it runs.
    if (state_q == CLEAR) begin
      fb_we_d   = 1'b1;
      fb_addr_d = clr_cnt_q;
      fb_data_d = clr_colour_q;
    end else if (s1_v_q) begin
      fb_we_d   = 1'b1;
      fb_addr_d = fb_addr_of(s1_q.x, s1_q.y, SCREEN_W);
      fb_data_d = s1_q.colour;
    end

    ready_d = (level_next != FULL_LVL) && (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      ready_q      <= 1'b0;
      clr_colour_q <= '0;
      clr_cnt_q    <= '0;
      s1_q         <= '0;
      s1_v_q       <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      fb_we_q      <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      clr_colour_q <= clr_colour_d;
      clr_cnt_q    <= clr_cnt_d;
      s1_q         <= s1_d;
      s1_v_q       <= s1_v_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
      fb_we_q      <= fb_we_d;
      drop_q       <= drop_d;
    end
  end

  assign ps.ready   = ready_q;
  assign busy       = (state_q != IDLE) || !empty;
  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;
  assign fb_we      = fb_we_q;
  assign drop_count = drop_q;
endmodule
